// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Frames follow each other with no idle gap while the FIFO holds data.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_uart_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count;
    logic          r_ready;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_idx, w_idx;
    logic [7:0]    r_shift, w_shift;
    logic          r_serial, r_active, r_done;
    logic          w_push, w_pop, w_empty, w_last, w_serial, w_active, w_done;

    assign w_push  = i_tx_valid && r_ready;
    assign w_empty = r_count == '0;
    assign w_last  = r_cnt == LAST;
    assign w_count = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    // Ready looks at the post-edge occupancy, so it rises the cycle after a pop frees a full FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count;
            r_ready <= w_count != FULL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_tx_data;
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_idx   = r_idx;
        w_shift = r_shift;
        w_pop   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    w_shift = r_mem[r_rd_ptr];
                    w_state = START;
                end
            end
            START: if (w_last) begin
                w_cnt   = '0;
                w_idx   = '0;
                w_state = DATA;
            end
            DATA: if (w_last) begin
                w_cnt = '0;
                w_idx = r_idx + 1'b1;
                if (r_idx == 3'd7) w_state = STOP;
            end
            STOP: if (w_last) begin
                w_cnt   = '0;
                w_state = IDLE;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    w_shift = r_mem[r_rd_ptr];
                    w_state = START;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered line lines up with r_state.
    assign w_serial = (w_state == START) ? 1'b0 : (w_state == DATA) ? w_shift[w_idx] : 1'b1;
    assign w_active = w_state != IDLE;
    assign w_done   = (w_state == STOP) && (w_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_shift  <= w_shift;
            r_serial <= w_serial;
            r_active <= w_active;
            r_done   <= w_done;
        end
    end

    assign o_tx_ready    = r_ready;
    assign o_uart_serial = r_serial;
    assign o_tx_active   = r_active;
    assign o_tx_done     = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed stimulus for uart_tx, checked by a line-level frame monitor.
module tb_uart_tx;
    localparam int CPB  = 4;
    localparam int FLEN = 10 * CPB;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_tx_valid = 1'b0;
    logic [7:0] i_tx_data = 8'h00;
    logic       o_tx_ready, o_uart_serial, o_tx_active, o_tx_done;

    int n_checks = 0;
    int n_fail = 0;
    int frames = 0;
    int accepted = 0;
    logic [7:0] exp_q[$];
    bit mon_en = 1'b0;
    bit in_frame = 1'b0;
    int mon_k = 0;
    logic [FLEN-1:0] cap_line, cap_act, cap_done;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_tx_valid(i_tx_valid),
        .i_tx_data(i_tx_data),
        .o_tx_ready(o_tx_ready),
        .o_uart_serial(o_uart_serial),
        .o_tx_active(o_tx_active),
        .o_tx_done(o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected frame: start 0, data LSB first, stop 1, each bit held CPB cycles.
    task automatic close_frame();
        logic [7:0] e, rx;
        logic [FLEN-1:0] exp_line;
        int b;
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int i = 0; i < FLEN; i++) begin
            b = i / CPB;
            exp_line[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[(b == 0) ? 0 : b - 1];
        end
        for (int j = 0; j < 8; j++) rx[j] = cap_line[(j + 1) * CPB + CPB / 2];
        check("frame_line", cap_line, exp_line);
        check("frame_active", cap_act, {FLEN{1'b1}});
        check("frame_done", cap_done, {1'b1, {(FLEN - 1){1'b0}}});
        check("rx_byte", rx, e);
        frames++;
    endtask

    always @(negedge i_clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
            mon_k = 0;
        end else if (!in_frame && o_uart_serial) begin
            check("idle_outputs", {o_tx_active, o_tx_done}, 2'b00);
        end else begin
            in_frame = 1'b1;
            cap_line[mon_k] = o_uart_serial;
            cap_act[mon_k]  = o_tx_active;
            cap_done[mon_k] = o_tx_done;
            mon_k++;
            if (mon_k == FLEN) begin
                close_frame();
                in_frame = 1'b0;
                mon_k = 0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        int n;
        n = 0;
        i_tx_valid = 1'b1;
        i_tx_data = d;
        while (!o_tx_ready && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        check("push_wait", o_tx_ready, 1);
        if (o_tx_ready) begin
            exp_q.push_back(d);
            accepted++;
        end
        @(negedge i_clk);
        i_tx_valid = 1'b0;
    endtask

    task automatic burst(input int n, input logic [7:0] start, output int first_drop);
        int cyc, k;
        cyc = 0;
        k = 0;
        first_drop = -1;
        i_tx_valid = 1'b1;
        while (k < n && cyc < 1000) begin
            i_tx_data = start + 8'(k);
            if (o_tx_ready) begin
                exp_q.push_back(i_tx_data);
                accepted++;
                k++;
            end else if (first_drop < 0) begin
                first_drop = k;
            end
            @(negedge i_clk);
            cyc++;
        end
        i_tx_valid = 1'b0;
        check("burst_complete", k, n);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((in_frame || exp_q.size() != 0 || o_tx_active) && n < 5000) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_pending", exp_q.size() + int'(in_frame) + int'(o_tx_active), 0);
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        int d, lows;
        logic [7:0] b;
        #1 i_rst_n = 1'b0;
        #1;
        check("rst_serial", o_uart_serial, 1);
        check("rst_active", o_tx_active, 0);
        check("rst_done", o_tx_done, 0);
        check("rst_ready", o_tx_ready, 1);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge i_clk);

        push_byte(8'hA5);
        check("lat_idle_after_accept", o_uart_serial, 1);
        @(negedge i_clk);
        check("lat_start_after_pop", o_uart_serial, 0);
        wait_idle();
        check("frames_single", frames, 1);

        push_byte(8'h00);
        push_byte(8'hFF);
        d = 0;
        for (int i = 0; i < 300 && o_tx_active; i++) begin
            d++;
            @(negedge i_clk);
        end
        check("b2b_active_cycles", d, 2 * FLEN);
        wait_idle();

        burst(6, 8'h01, d);
        check("accepted_before_full", d, 5);
        wait_idle();

        b = 8'($urandom);
        burst(5, b, d);
        check("full_ready_low", o_tx_ready, 0);
        d = 0;
        while (!o_tx_done && d < 200) begin
            @(negedge i_clk);
            d++;
        end
        check("done_seen", o_tx_done, 1);
        i_tx_valid = 1'b1;
        i_tx_data = 8'h77;
        check("pop_cycle_ready", o_tx_ready, 0);
        @(negedge i_clk);
        check("ready_rise", o_tx_ready, 1);
        i_tx_valid = 1'b0;
        wait_idle();

        b = 8'($urandom) & 8'hF7;
        burst(3, b, d);
        d = 0;
        while (mon_k < 17 && d < 200) begin
            @(negedge i_clk);
            d++;
        end
        check("reached_bit3", mon_k >= 17 && mon_k < 20, 1);
        mon_en = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_mid_serial", o_uart_serial, 1);
        check("rst_mid_active", o_tx_active, 0);
        check("rst_mid_done", o_tx_done, 0);
        check("rst_mid_ready", o_tx_ready, 1);
        accepted -= exp_q.size();
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_en = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge i_clk);
            if (!o_uart_serial || o_tx_active) lows++;
        end
        check("quiet_after_rst", lows, 0);
        check("ready_after_rst", o_tx_ready, 1);
        push_byte(8'($urandom));
        wait_idle();

        repeat (40) begin
            push_byte(8'($urandom));
            repeat ($urandom_range(0, 12)) @(negedge i_clk);
        end
        wait_idle();

        for (int v = 0; v < 256; v++) begin
            push_byte(8'(v));
            repeat ($urandom_range(0, 6)) @(negedge i_clk);
        end
        wait_idle();
        check("frames_total", frames, accepted);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
